// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// muldiv_unit_pkg : shared ALU / RV32M opcode definitions and helpers
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  function automatic logic md_signed_rs1(input muldiv_op_e op);
    case (op)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  function automatic logic md_signed_rs2(input muldiv_op_e op);
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input muldiv_op_e op);
    case (op)
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
// ============================================================================
// muldiv_sign_fix : combinational conditional two's-complement negate
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign data_o = neg_i ? (~data_i + C_ONE) : data_i;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative radix-2 RV32M multiply/divide, fixed 33-edge latency
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [2:0]  MULDIV_OPCODE,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] MULDIV_RESULT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        last_q,  last_d;
  logic [63:0] acc_q,   acc_d;
  logic [31:0] opb_q,   opb_d;
  muldiv_op_e  op_q,    op_d;
  logic        sa_q,    sa_d;
  logic        sb_q,    sb_d;
  logic [31:0] res_q,   res_d;

  muldiv_op_e  op_in;
  logic        neg_a_in, neg_b_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign op_in    = muldiv_op_e'(MULDIV_OPCODE);
  assign neg_a_in = md_signed_rs1(op_in) & DATA1[31];
  assign neg_b_in = md_signed_rs2(op_in) & DATA2[31];

  muldiv_sign_fix #(.WIDTH(32)) u_fix_a (.data_i(DATA1), .neg_i(neg_a_in), .data_o(mag_a));
  muldiv_sign_fix #(.WIDTH(32)) u_fix_b (.data_i(DATA2), .neg_i(neg_b_in), .data_o(mag_b));

  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
  // Partial remainder shifted left by one, minus divisor; bit 32 is the borrow
  assign div_diff = acc_q[63:31] - {1'b0, opb_q};

  muldiv_sign_fix #(.WIDTH(64)) u_fix_prod (
    .data_i(acc_q), .neg_i(sa_q ^ sb_q), .data_o(prod_fix));
  // A zero divisor keeps the all-ones quotient regardless of dividend sign
  muldiv_sign_fix #(.WIDTH(32)) u_fix_quot (
    .data_i(acc_q[31:0]), .neg_i((sa_q ^ sb_q) & (|opb_q)), .data_o(quot_fix));
  muldiv_sign_fix #(.WIDTH(32)) u_fix_rem (
    .data_i(acc_q[63:32]), .neg_i(sa_q), .data_o(rem_fix));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      last_q  <= 1'b0;
      acc_q   <= 64'd0;
      opb_q   <= 32'd0;
      op_q    <= MD_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_CALC;
          cnt_d   = 5'd0;
          last_d  = 1'b0;
          acc_d   = {32'd0, mag_a};
          opb_d   = mag_b;
          op_d    = op_in;
          sa_d    = neg_a_in;
          sb_d    = neg_b_in;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (!last_q) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            last_d = 1'b1;
          end
          if (md_is_div(op_q)) begin
            acc_d = div_diff[32] ? {acc_q[62:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
          end
        end else begin
          // Iterations finished: sign-correct and publish the result
          state_d = ST_DONE;
          last_d  = 1'b0;
          case (op_q)
            MD_MUL:                       res_d = prod_fix[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod_fix[63:32];
            MD_DIV, MD_DIVU:              res_d = quot_fix;
            default:                      res_d = rem_fix;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY          = (state_q == ST_CALC) && !last_q;
  assign DONE          = (state_q == ST_DONE);
  assign MULDIV_RESULT = res_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic [31:0] data1, data2;
  logic [2:0]  opcode;
  logic        start;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit dut (
    .CLK          (clk),
    .RESET        (rst),
    .DATA1        (data1),
    .DATA2        (data2),
    .MULDIV_OPCODE(opcode),
    .START        (start),
    .BUSY         (busy),
    .DONE         (done),
    .MULDIV_RESULT(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accepting edge E0
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op;
    data1  = a;
    data2  = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Entered at a negedge 'already' edges after E0, with BUSY high for those samples
  task automatic wait_done(input string tag, input logic [31:0] exp, input int already);
    int edges;
    int busy_cnt;
    edges    = already;
    busy_cnt = already;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
    check({tag, "_lat"},  edges, 32'd33);
    check({tag, "_busy"}, busy_cnt, 32'd32);
    check({tag, "_res"},  result, exp);
    check({tag, "_ovl"},  {31'd0, busy & done}, 32'd0);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},  // MUL 7*-3
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},  // MULHU
    '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},  // MULH -1*-1
    '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},  // MULHSU -1*2
    '{3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA},  // DIV -20/3
    '{3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE},  // REM -20%3
    '{3'd5, 32'h0000_0014, 32'h0000_0003, 32'h0000_0006},  // DIVU 20/3
    '{3'd7, 32'h0000_0014, 32'h0000_0003, 32'h0000_0002},  // REMU 20%3
    '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},  // DIVU /0
    '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},  // REMU %0
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},  // DIV overflow
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},  // REM overflow
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF},  // DIV -7/0
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},  // REM -7%0
    '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000},  // MUL 2^16*2^16
    '{3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001}   // MULHU 2^16*2^16
  };

  initial begin
    rst    = 1'b1;
    start  = 1'b1;
    data1  = 32'h0000_0007;
    data2  = 32'hFFFF_FFFD;
    opcode = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res",  result, 32'd0);

    // START held through reset: accepted on the first edge with reset low
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("rst_prio", 32'hFFFF_FFEB, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].exp, 0);
    end

    // Result holds after the DONE pulse
    @(negedge clk);
    check("hold_done", {31'd0, done}, 32'd0);
    check("hold_res",  result, 32'h0000_0001);

    // START during iteration 5 is ignored
    @(negedge clk);
    start_op(3'd0, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    opcode = 3'd5;
    data1  = 32'd100;
    data2  = 32'd0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done("ignore", 32'h0000_002A, 6);

    // Reset at iteration 10 discards the operation
    @(negedge clk);
    start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_res",  result, 32'd0);
    @(negedge clk);
    start_op(3'd5, 32'd100, 32'd7);
    wait_done("after_rst", 32'd14, 0);

    // Back-to-back: START high in the DONE cycle
    @(negedge clk);
    start_op(3'd7, 32'd100, 32'd7);
    wait_done("b2b_first", 32'd2, 0);
    start_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("b2b_second", 32'd1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous active-high reset.
REQ-004 DATA1  input  32  operand rs1, sampled only on an accepted START.
REQ-005 DATA2  input  32  operand rs2, sampled only on an accepted START.
REQ-006 MULDIV_OPCODE  input  3  RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7; sampled with START.
REQ-007 START  input  1  request pulse; accepted when state is IDLE or DONE.
REQ-008 BUSY  output  1  high while an operation is iterating (state CALC only).
REQ-009 DONE  output  1  one-cycle pulse; RESULT valid in this cycle.
REQ-010 MULDIV_RESULT  output  32  result; holds last value until the next DONE or RESET.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on accepted START; CALC->DONE after 32 iteration edges; DONE->IDLE, or DONE->CALC if START is high in the DONE cycle.
REQ-012 SHALL latch operands and opcode and clear the 5-bit iteration counter on the START-accepting edge (E0).
REQ-013 SHALL perform one radix-2 step per edge E1..E32: shift-add for multiply (64-bit product), restoring shift-subtract for divide.
REQ-014 SHALL operate on magnitudes: signed operands (MUL/MULH/DIV/REM: both; MULHSU: DATA1 only) are negated if negative at E0.
REQ-015 SHALL apply sign correction on the edge E33 entering DONE: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
REQ-016 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-017 Divide by zero SHALL return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = DATA1 (REM and REMU).
REQ-018 DIV 0x80000000 by 0xFFFFFFFF SHALL return 0x80000000; REM SHALL return 0.
REQ-019 Latency SHALL be fixed: DONE is high in the cycle after edge E33 for every opcode and every special case.
REQ-020 START while BUSY=1 SHALL be ignored, with no effect on operands or state.
REQ-021 DONE SHALL never be high while BUSY is high.

Reset
REQ-022 On RESET at any edge, including mid-CALC, the block SHALL enter IDLE with BUSY=0, DONE=0, MULDIV_RESULT=0, counter=0, and discard the in-flight operation.
REQ-023 RESET SHALL take priority over a simultaneous START; START is accepted on the first edge with RESET low.

Structure
REQ-024 The MULDIV_OPCODE encodings SHALL be added to the shared definitions file beside the ALU opcodes; state encodings SHALL stay local.
REQ-025 The datapath SHALL be one 64-bit accumulator/remainder register plus a 32-bit operand register, shared between multiply and divide.
REQ-026 One sub-module is natural: muldiv_sign_fix, a combinational conditional two's-complement negate used at E0 and E33.
REQ-027 Implementation target: 120-400 lines of RTL.

Verification
REQ-028 MUL 7 by 0xFFFFFFFD (-3) -> 0xFFFFFFEB; DONE exactly 33 edges after the START edge; BUSY high for 32 cycles.
REQ-029 MULHU 0xFFFFFFFF by 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF by 2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFEC (-20) by 3 -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; DIVU 20 by 3 -> 6; REMU -> 2.
REQ-031 DIVU 5 by 0 -> 0xFFFFFFFF; REMU 5 by 0 -> 5; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM -> 0; latency 33 in each case.
REQ-032 RESET asserted at iteration 10 -> next cycle BUSY=0, DONE=0, MULDIV_RESULT=0; a START issued afterwards completes correctly.
REQ-033 START pulsed at iteration 5 -> ignored, result unchanged; START held high during the DONE cycle -> back-to-back operation accepted, second DONE 33 edges later.
